// File: rtl/dup_adder_checker_78.sv
// rtl/dup_adder_checker_78.sv - duplication checker for the 78-bit carry-select adder; counter under DUP_CHECKER_ERR_CNT_EN
module dup_adder_checker_78 #(
    parameter int W     = 78,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s,
    input  logic [W-1:0]     s_invert,
    input  logic             papb,
    input  logic             pab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_papb,
    output logic             out_pab,
    output logic             out_err,
    output logic [6:0]       out_err_idx,
    input  logic             clr_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    logic         v1, v2;
    logic [W-1:0] s1, s_inv1;
    logic         papb1, pab1;
    logic         adv2, accept, load_err;
    logic [W-1:0] eq;
    logic         err;
    logic [6:0]   idx;

    assign adv2      = v1 & (~v2 | out_ready);
    assign in_ready  = ~v1 | adv2;
    assign accept    = in_valid & in_ready;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1     <= '0;
            s_inv1 <= '0;
            papb1  <= 1'b0;
            pab1   <= 1'b0;
        end else begin
            v1 <= accept | (v1 & ~adv2);
            if (accept) begin
                s1     <= s;
                s_inv1 <= s_invert;
                papb1  <= papb;
                pab1   <= pab;
            end
        end
    end

    // A healthy duplicate differs from the primary in every bit; any equal bit is a fault.
    assign eq  = ~(s1 ^ s_inv1);
    assign err = |eq;

    always_comb begin
        idx = 7'd127;
        for (int i = W - 1; i >= 0; i--) begin
            if (eq[i]) idx = 7'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2          <= 1'b0;
            out_sum     <= '0;
            out_papb    <= 1'b0;
            out_pab     <= 1'b0;
            out_err     <= 1'b0;
            out_err_idx <= 7'd127;
        end else begin
            v2 <= adv2 | (v2 & ~out_ready);
            if (adv2) begin
                out_sum     <= s1;
                out_papb    <= papb1;
                out_pab     <= pab1;
                out_err     <= err;
                out_err_idx <= idx;
            end
        end
    end

    // Bookkeeping tracks entry into S2, so a coincident clear still records the new fault.
    assign load_err = adv2 & err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (clr_err) begin
            err_sticky <= load_err;
        end else if (load_err) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef DUP_CHECKER_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_err) begin
            cnt_q <= load_err ? CNT_W'(1) : '0;
        end else if (load_err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_dup_adder_checker_78.sv
// tb/tb_dup_adder_checker_78.sv - table and scoreboard bench for dup_adder_checker_78
module tb_dup_adder_checker_78;

    localparam int W     = 78;
    localparam int CNT_W = 16;
`ifdef DUP_CHECKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     s;
    logic [W-1:0]     s_invert;
    logic             papb;
    logic             pab;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic             out_papb;
    logic             out_pab;
    logic             out_err;
    logic [6:0]       out_err_idx;
    logic             clr_err;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;

    dup_adder_checker_78 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .s_invert(s_invert), .papb(papb), .pab(pab),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_papb(out_papb), .out_pab(out_pab),
        .out_err(out_err), .out_err_idx(out_err_idx),
        .clr_err(clr_err), .err_sticky(err_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         pa;
        logic         pb;
        logic         err;
        logic [6:0]   idx;
        int           acc_cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         pa;
        logic         pb;
        logic         err;
        logic [6:0]   idx;
    } vec_t;

    exp_t         q[$];
    exp_t         nxt;
    vec_t         tbl[6];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_pop = 0;
    int           first_pop = -1;
    int           last_pop = 0;
    int           first_lat = 0;
    int           exp_cnt = 0;
    bit           exp_sticky = 1'b0;
    bit           hold_pend = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_err;
    logic [6:0]   hold_idx;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic pa, input logic pb);
        exp_t         e;
        logic [W-1:0] eqv;
        eqv     = ~(a ^ b);
        e.sum   = a;
        e.pa    = pa;
        e.pb    = pb;
        e.err   = |eqv;
        e.idx   = 7'd127;
        e.acc_cyc = 0;
        for (int i = 0; i < W; i++) begin
            if (eqv[i]) begin
                e.idx = 7'(i);
                break;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input bit ok, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic pa, input logic pb, input logic v);
        in_valid = v;
        s        = a;
        s_invert = b;
        papb     = pa;
        pab      = pb;
        nxt      = model(a, b, pa, pb);
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (hold_pend)
            check("hold", out_valid && out_sum == hold_sum && out_err == hold_err &&
                  out_err_idx == hold_idx, 128'(out_sum), 128'(hold_sum));
        hold_pend = out_valid && !out_ready;
        hold_sum  = out_sum;
        hold_err  = out_err;
        hold_idx  = out_err_idx;
        if (in_valid && in_ready) begin
            e = nxt;
            e.acc_cyc = cyc;
            q.push_back(e);
            n_acc++;
            if (e.err) begin
                exp_sticky = 1'b1;
                if (exp_cnt < 65535) exp_cnt++;
            end
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1'b0, 128'(out_sum), 128'(0));
            end else begin
                e = q.pop_front();
                check("sb_word", out_sum == e.sum && out_papb == e.pa && out_pab == e.pb &&
                      out_err == e.err && out_err_idx == e.idx && (!e.err || err_sticky),
                      {out_err_idx, out_err, out_papb, out_pab, 1'b0, out_sum},
                      {e.idx, e.err, e.pa, e.pb, 1'b0, e.sum});
                n_pop++;
                if (first_pop < 0) begin
                    first_pop = cyc;
                    first_lat = cyc - e.acc_cyc;
                end
                last_pop = cyc;
            end
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        check("drain", q.size() == 0, 128'(q.size()), 128'(0));
    endtask

    task automatic check_ctrs(input string name);
        check({name, "_sticky"}, err_sticky == exp_sticky, 128'(err_sticky), 128'(exp_sticky));
        check({name, "_count"}, err_count == (CNT_EN ? CNT_W'(exp_cnt) : CNT_W'(0)),
              128'(err_count), 128'(CNT_EN ? exp_cnt : 0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] tmp;
        logic [W-1:0] r;
        int           base_acc;
        int           base_pop;

        r = {$urandom, $urandom, $urandom};
        tbl[0] = '{a: r, b: ~r, pa: 1'b1, pb: 1'b0, err: 1'b0, idx: 7'd127};
        tmp = ~r; tmp[5] = r[5]; tmp[70] = r[70];
        tbl[1] = '{a: r, b: tmp, pa: 1'b0, pb: 1'b1, err: 1'b1, idx: 7'd5};
        tmp = ~r; tmp[0] = r[0];
        tbl[2] = '{a: r, b: tmp, pa: 1'b1, pb: 1'b1, err: 1'b1, idx: 7'd0};
        tmp = ~r; tmp[77] = r[77];
        tbl[3] = '{a: r, b: tmp, pa: 1'b0, pb: 1'b0, err: 1'b1, idx: 7'd77};
        tbl[4] = '{a: r, b: r, pa: 1'b1, pb: 1'b0, err: 1'b1, idx: 7'd0};
        tbl[5] = '{a: '1, b: '0, pa: 1'b0, pb: 1'b1, err: 1'b0, idx: 7'd127};

        rst_n = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid == 1'b0, 128'(out_valid), 128'(0));
        check("rst_in_ready", in_ready == 1'b1, 128'(in_ready), 128'(1));
        check("rst_out_sum", out_sum == '0 && out_papb == 1'b0 && out_pab == 1'b0,
              128'(out_sum), 128'(0));
        check("rst_err_idx", out_err == 1'b0 && out_err_idx == 7'd127,
              {out_err, out_err_idx}, {1'b0, 7'd127});
        check_ctrs("rst");
        rst_n = 1'b1;
        cycle();

        // clean back-to-back stream
        for (int k = 1; k <= 10; k++) begin
            tmp = W'(k);
            drive(tmp, ~tmp, tmp[0], tmp[1], 1'b1);
            cycle();
        end
        drain();
        check("clean_pops", n_pop == 10, 128'(n_pop), 128'(10));
        check("clean_no_bubbles", last_pop - first_pop == 9, 128'(last_pop - first_pop), 128'(9));
        check("clean_latency", first_lat == 2, 128'(first_lat), 128'(2));
        check_ctrs("clean");

        // single-bit fault, output and counters on the same edge
        tmp = '1; tmp[37] = 1'b0;
        drive('0, tmp, 1'b0, 1'b1, 1'b1);
        cycle();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("bit37_valid", out_valid == 1'b1 && out_err == 1'b1, {out_valid, out_err}, 2'b11);
        check("bit37_idx", out_err_idx == 7'd37, 128'(out_err_idx), 128'(37));
        check_ctrs("bit37");
        drain();

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].pa, tbl[i].pb, 1'b1);
            nxt.err = tbl[i].err;
            nxt.idx = tbl[i].idx;
            cycle();
        end
        drain();
        check_ctrs("table");

        // back-pressure: 5 stalled cycles with input offered every cycle
        base_acc  = n_acc;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tmp = W'(100 + i);
            drive(tmp, ~tmp, 1'b0, 1'b0, 1'b1);
            cycle();
        end
        check("bp_accepts", n_acc - base_acc == 2, 128'(n_acc - base_acc), 128'(2));
        check("bp_in_ready", in_ready == 1'b0, 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        for (int i = 5; i < 8; i++) begin
            tmp = W'(100 + i);
            drive(tmp, ~tmp, 1'b1, 1'b0, 1'b1);
            cycle();
        end
        drain();
        check("bp_conserved", n_pop == n_acc, 128'(n_pop), 128'(n_acc));

        // saturating counter
        for (int i = 0; i < 65540; i++) begin
            tmp = W'(i);
            drive(tmp, tmp, 1'b0, 1'b0, 1'b1);
            cycle();
        end
        drain();
        check_ctrs("saturate");

        // clear coinciding with a fault entering S2
        tmp = '1; tmp[12] = 1'b0;
        drive('0, tmp, 1'b0, 1'b0, 1'b1);
        cycle();
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        exp_cnt = 1; exp_sticky = 1'b1;
        check_ctrs("clr_coinc");
        drain();

        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        exp_cnt = 0; exp_sticky = 1'b0;
        check_ctrs("clr_alone");

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        drive('0, '0, 1'b1, 1'b1, 1'b1);
        cycle();
        tmp = W'(55);
        drive(tmp, ~tmp, 1'b0, 1'b0, 1'b1);
        cycle();
        check("full_in_ready", in_ready == 1'b0, 128'(in_ready), 128'(0));
        check("full_sticky", err_sticky == 1'b1, 128'(err_sticky), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid == 1'b0, 128'(out_valid), 128'(0));
        check("arst_idx", out_err_idx == 7'd127 && out_err == 1'b0 && out_sum == '0,
              {out_err, out_err_idx}, {1'b0, 7'd127});
        q.delete(); hold_pend = 1'b0; exp_cnt = 0; exp_sticky = 1'b0;
        check_ctrs("arst");
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        check("arst_in_ready", in_ready == 1'b1, 128'(in_ready), 128'(1));
        @(posedge clk);
        #2;
        base_pop  = n_pop;
        out_ready = 1'b1;
        tmp = W'(77);
        drive(tmp, ~tmp, 1'b1, 1'b0, 1'b1);
        cycle();
        drain();
        check("arst_after", n_pop - base_pop == 1, 128'(n_pop - base_pop), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
